// File: rtl/demux_1to5_reg.sv
// Routes a 16-bit write to one of five holding registers, or broadcasts it to all five one per cycle.
// Single write lands 1 edge after acceptance; a broadcast fills a..e over 5 edges; wr_en is ignored while busy.
module demux_1to5_reg (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] in,
  input  logic [2:0]  sel,
  input  logic        wr_en,
  input  logic        bcast,
  input  logic        err_clr,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic [15:0] d,
  output logic [15:0] e,
  output logic [4:0]  upd,
  output logic        wr_ack,
  output logic        busy,
  output logic        err
);

  typedef enum logic {IDLE = 1'b0, BCAST = 1'b1} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [15:0] hold;
  logic [15:0] regs [5];

  logic [4:0]  we;
  logic [15:0] wdata;
  logic        ack_nxt;
  logic        err_set;
  logic        accept_bc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= (state_nxt == BCAST);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (wr_en && bcast) state_nxt = BCAST;
      BCAST:   if (cnt == 3'd4)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Broadcast writes come from hold, so later changes on in cannot leak into a..e.
  always_comb begin
    we        = 5'b00000;
    wdata     = in;
    ack_nxt   = 1'b0;
    err_set   = 1'b0;
    accept_bc = 1'b0;
    case (state)
      IDLE: begin
        if (wr_en) begin
          if (bcast) begin
            accept_bc = 1'b1;
          end else if (sel <= 3'd4) begin
            we      = 5'b00001 << sel;
            ack_nxt = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      BCAST: begin
        wdata   = hold;
        we      = 5'b00001 << cnt;
        ack_nxt = (cnt == 3'd4);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      upd    <= 5'b00000;
      wr_ack <= 1'b0;
      err    <= 1'b0;
      hold   <= 16'h0000;
      cnt    <= 3'd0;
      for (int k = 0; k < 5; k++) regs[k] <= 16'h0000;
    end else begin
      upd    <= we;
      wr_ack <= ack_nxt;
      // An illegal select at the same edge as err_clr leaves err set.
      err    <= err_set | (err & ~err_clr);
      if (accept_bc) begin
        hold <= in;
        cnt  <= 3'd0;
      end else if (state == BCAST) begin
        cnt  <= cnt + 3'd1;
      end
      for (int k = 0; k < 5; k++) begin
        if (we[k]) regs[k] <= wdata;
      end
    end
  end

  assign a = regs[0];
  assign b = regs[1];
  assign c = regs[2];
  assign d = regs[3];
  assign e = regs[4];

endmodule

// File: tb/tb_demux_1to5_reg.sv
// Bench for demux_1to5_reg: directed scenarios plus random traffic, checked against a queue-based model.
`timescale 1ns/1ps
module tb_demux_1to5_reg;

  logic        clk;
  logic        reset_n;
  logic [15:0] din;
  logic [2:0]  sel;
  logic        wr_en;
  logic        bcast;
  logic        err_clr;
  logic [15:0] a, b, c, d, e;
  logic [4:0]  upd;
  logic        wr_ack;
  logic        busy;
  logic        err;

  int errors = 0;
  int checks = 0;

  demux_1to5_reg dut (
    .clk(clk), .reset_n(reset_n), .in(din), .sel(sel), .wr_en(wr_en),
    .bcast(bcast), .err_clr(err_clr), .a(a), .b(b), .c(c), .d(d), .e(e),
    .upd(upd), .wr_ack(wr_ack), .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [87:0] obs;
  assign obs = {a, b, c, d, e, upd, wr_ack, busy, err};

  // Model: register file plus a queue of register indices still owed by a broadcast.
  logic [15:0] m_reg [5];
  logic [4:0]  m_upd;
  logic        m_ack;
  logic        m_err;
  logic [15:0] m_bval;
  int          bq[$];

  function automatic logic [87:0] mexp();
    return {m_reg[0], m_reg[1], m_reg[2], m_reg[3], m_reg[4], m_upd, m_ack, (bq.size() != 0), m_err};
  endfunction

  task model_clear();
    for (int k = 0; k < 5; k++) m_reg[k] = 16'h0000;
    m_upd = 5'b0; m_ack = 1'b0; m_err = 1'b0; m_bval = 16'h0000;
    bq.delete();
  endtask

  task model_step();
    int  k;
    logic illegal;
    illegal = 1'b0;
    if (!reset_n) begin
      model_clear();
      return;
    end
    m_upd = 5'b0;
    m_ack = 1'b0;
    if (bq.size() > 0) begin
      k = bq.pop_front();
      m_reg[k] = m_bval;
      m_upd = 5'(1 << k);
      if (bq.size() == 0) m_ack = 1'b1;
    end else if (wr_en && bcast) begin
      m_bval = din;
      bq = {0, 1, 2, 3, 4};
    end else if (wr_en && sel < 3'd5) begin
      m_reg[sel] = din;
      m_upd = 5'(1 << sel);
      m_ack = 1'b1;
    end else if (wr_en) begin
      illegal = 1'b1;
    end
    if (illegal) m_err = 1'b1;
    else if (err_clr) m_err = 1'b0;
  endtask

  task drive(input logic w, input logic bc, input logic [2:0] s, input logic [15:0] dv, input logic ec);
    wr_en = w; bcast = bc; sel = s; din = dv; err_clr = ec;
  endtask

  task step();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 3'd1, 16'hBEEF, 1'b0);
    model_clear();
    repeat (2) step();
    checks++;
    if (obs !== 88'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", obs);
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    reset_n = 1'b1;
    step();
    checks++;
    if (obs !== mexp()) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", obs, mexp());
    end
  endtask

  task test_single_writes();
    logic [15:0] vals [5];
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 3'(k), vals[k], 1'b0);
      step();
      checks++;
      if (upd !== 5'(1 << k) || wr_ack !== 1'b1 || obs !== mexp()) begin
        errors++;
        $display("FAIL single_write_%0d: got %h expected %h upd=%b", k, obs, mexp(), upd);
      end
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    step();
    checks++;
    if ({a, b, c, d, e} !== {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555}
        || upd !== 5'b0 || wr_ack !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_final: got %h", obs);
    end
  endtask

  task test_illegal();
    drive(1'b1, 1'b0, 3'd5, 16'hDEAD, 1'b0);
    step();
    checks++;
    if (err !== 1'b1 || wr_ack !== 1'b0 || upd !== 5'b0 || obs !== mexp()) begin
      errors++;
      $display("FAIL illegal_sel5: got %h expected %h", obs, mexp());
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
    step();
    checks++;
    if (err !== 1'b0 || obs !== mexp()) begin
      errors++;
      $display("FAIL err_clear: got %h expected %h", obs, mexp());
    end
    drive(1'b1, 1'b0, 3'd7, 16'hDEAD, 1'b1);
    step();
    checks++;
    if (err !== 1'b1 || obs !== mexp()) begin
      errors++;
      $display("FAIL set_wins: got %h expected %h", obs, mexp());
    end
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b1);
    step();
  endtask

  task test_bcast();
    int acks;
    int busys;
    acks = 0; busys = 0;
    drive(1'b1, 1'b1, 3'd6, 16'hA5A5, 1'b0);
    step();
    busys += busy;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) drive(1'b1, 1'b0, 3'd2, 16'hFFFF, 1'b0);
      else drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
      step();
      acks += wr_ack;
      busys += busy;
      checks++;
      if (upd !== 5'(1 << (k - 1)) || obs !== mexp()) begin
        errors++;
        $display("FAIL bcast_edge_%0d: got %h expected %h", k, obs, mexp());
      end
    end
    step();
    acks += wr_ack;
    checks++;
    if ({a, b, c, d, e} !== {5{16'hA5A5}} || acks != 1 || busys != 5 || err !== 1'b0) begin
      errors++;
      $display("FAIL bcast_result: regs=%h acks=%0d busy_cycles=%0d err=%b want A5A5x5 1 5 0",
               {a, b, c, d, e}, acks, busys, err);
    end
  endtask

  task test_reset_mid_bcast();
    int acks;
    acks = 0;
    drive(1'b1, 1'b1, 3'd0, 16'h00FF, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    step();
    step();
    reset_n = 1'b0;
    #1;
    model_clear();
    checks++;
    if (obs !== 88'h0) begin
      errors++;
      $display("FAIL reset_mid_bcast: got %h expected 0", obs);
    end
    step();
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      acks += wr_ack;
    end
    checks++;
    if (acks != 0 || busy !== 1'b0 || obs !== mexp()) begin
      errors++;
      $display("FAIL after_reset_mid: got %h expected %h acks=%0d", obs, mexp(), acks);
    end
  endtask

  task test_back_to_back();
    drive(1'b1, 1'b1, 3'd0, 16'h0F0F, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    repeat (5) step();
    checks++;
    if (wr_ack !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_ack_cycle: wr_ack=%b busy=%b expected 1 0", wr_ack, busy);
    end
    drive(1'b1, 1'b0, 3'd1, 16'h1234, 1'b0);
    step();
    drive(1'b0, 1'b0, 3'd0, 16'h0000, 1'b0);
    checks++;
    if ({a, b, c, d, e} !== {16'h0F0F, 16'h1234, 16'h0F0F, 16'h0F0F, 16'h0F0F}
        || upd !== 5'b00010 || wr_ack !== 1'b1 || obs !== mexp()) begin
      errors++;
      $display("FAIL b2b_write: got %h expected %h", obs, mexp());
    end
  endtask

  task test_random();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom_range(0, 9) < 7), ($urandom_range(0, 9) == 0), 3'($urandom_range(0, 7)),
            16'($urandom), ($urandom_range(0, 4) == 0));
      step();
      checks++;
      if (obs !== mexp()) begin
        errors++;
        $display("FAIL random_%0d: got %h expected %h", n, obs, mexp());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_writes();
    test_illegal();
    test_bcast();
    test_reset_mid_bcast();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
